uart_cmd_decoder: RTL and testbench

Receive-side command stage placed directly downstream of the UART receiver in the Stopwatch_Watch design. It takes each received byte (data plus a one-cycle done strobe) and buffers it in a small FIFO. It decodes ASCII command characters into one-cycle control pulses that are equivalent to the board buttons, and spaces consecutive pulses by a guaranteed gap so the stopwatch/watch FSMs never miss or merge commands. ESC bytes bypass the FIFO and flush pending commands, in step with the ESC-triggered timer reset.

---
 rtl/uart_cmd_decoder.sv | 168 ++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder
// Receive-side command stage behind the UART receiver. Received bytes are
// buffered in a small FIFO. Command characters are decoded into one-cycle
// button-equivalent pulses. Each pulse is followed by a forced idle gap. ESC
// (8'h1B) bypasses the FIFO, flushes it, and returns the FSM to IDLE.
//
// Parameters:
//   FIFO_DEPTH - byte FIFO depth (power of two, >= 2)
//   GAP_CYCLES - idle cycles forced after every emitted pulse (>= 1)
//
// Ports:
//   clk, rst    - clock; asynchronous active-high reset
//   rx_done     - one-cycle strobe, rx_data valid in the same cycle
//   rx_data     - received byte
//   o_run/o_clear/o_mode/o_hour/o_min - one-cycle command pulses
//   o_busy      - FIFO non-empty or FSM not idle
//   o_full      - FIFO full
//   o_overflow  - sticky, a byte was dropped while the FIFO was full
//   o_count     - FIFO occupancy
//
// Configuration macro: UART_CMD_UPPER_EN - also accept uppercase command letters.
module uart_cmd_decoder #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx_done,
  input  logic [7:0]                   rx_data,
  output logic                         o_run,
  output logic                         o_clear,
  output logic                         o_mode,
  output logic                         o_hour,
  output logic                         o_min,
  output logic                         o_busy,
  output logic                         o_full,
  output logic                         o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]  o_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned GW = $clog2(GAP_CYCLES) + 1;
  localparam logic [7:0]  ESC = 8'h1B;

  typedef enum logic [1:0] {IDLE, FETCH, EMIT, GAP} state_t;

  state_t         state, state_next;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic [7:0]     cmd_reg;
  logic [GW-1:0]  gap_cnt, gap_next;
  logic [4:0]     pulse, pulse_next;   // {min, hour, mode, clear, run}
  logic           overflow;
  logic           esc, full, rd_en, wr_en;
  logic [4:0]     cmd_dec;

  // One-hot pulse select for a command byte; zero for ignored bytes.
  function automatic logic [4:0] decode(input logic [7:0] b);
    logic [4:0] d;
    d = '0;
    case (b)
      8'h72: d = 5'b00001;  // r
      8'h63: d = 5'b00010;  // c
      8'h6D: d = 5'b00100;  // m
      8'h68: d = 5'b01000;  // h
      8'h6E: d = 5'b10000;  // n
`ifdef UART_CMD_UPPER_EN
      8'h52: d = 5'b00001;  // R
      8'h43: d = 5'b00010;  // C
      8'h4D: d = 5'b00100;  // M
      8'h48: d = 5'b01000;  // H
      8'h4E: d = 5'b10000;  // N
`endif
      default: d = '0;
    endcase
    return d;
  endfunction

  always_comb begin
    esc     = rx_done && (rx_data == ESC);
    full    = (count == CW'(FIFO_DEPTH));
    // ESC wins over a pop: the flush discards the head as well.
    rd_en   = (state == IDLE) && (count != '0) && !esc;
    // A full FIFO still accepts a byte when the head leaves on the same edge.
    wr_en   = rx_done && !esc && (!full || rd_en);
    cmd_dec = decode(cmd_reg);
  end

  always_comb begin
    state_next = state;
    gap_next   = gap_cnt;
    pulse_next = '0;
    case (state)
      IDLE:  if (count != '0) state_next = FETCH;
      FETCH: begin
        if (cmd_dec != '0) begin
          state_next = EMIT;
          pulse_next = cmd_dec;
        end else begin
          state_next = IDLE;
        end
      end
      EMIT: begin
        state_next = GAP;
        gap_next   = GW'(GAP_CYCLES - 1);
      end
      GAP: begin
        if (gap_cnt == '0) state_next = IDLE;
        else               gap_next   = gap_cnt - GW'(1);
      end
      default: state_next = IDLE;
    endcase
    if (esc) begin
      state_next = IDLE;
      pulse_next = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gap_cnt  <= '0;
      pulse    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      cmd_reg  <= '0;
      overflow <= 1'b0;
    end else begin
      state   <= state_next;
      gap_cnt <= gap_next;
      pulse   <= pulse_next;
      if (rd_en) cmd_reg <= mem[rd_ptr];
      if (rx_done && !esc && !wr_en) overflow <= 1'b1;
      if (esc) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + AW'(1);
        if (rd_en) rd_ptr <= rd_ptr + AW'(1);
        case ({wr_en, rd_en})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= rx_data;
  end

  assign o_run      = pulse[0];
  assign o_clear    = pulse[1];
  assign o_mode     = pulse[2];
  assign o_hour     = pulse[3];
  assign o_min      = pulse[4];
  assign o_busy     = (count != '0) || (state != IDLE);
  assign o_full     = full;
  assign o_overflow = overflow;
  assign o_count    = count;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Testbench for uart_cmd_decoder. The reference model is a transaction-level
// scheduler. A byte queue stands in for the FIFO. The decoder is reduced to
// "earliest edge at which the next byte may be taken" plus one scheduled
// pulse. The bench also honours UART_CMD_UPPER_EN.
module tb_uart_cmd_decoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned GAPC  = 4;

  logic       clk, rst, rx_done;
  logic [7:0] rx_data;
  logic       o_run, o_clear, o_mode, o_hour, o_min, o_busy, o_full, o_overflow;
  logic [2:0] o_count;

  uart_cmd_decoder #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAPC)) dut (
    .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data),
    .o_run(o_run), .o_clear(o_clear), .o_mode(o_mode), .o_hour(o_hour),
    .o_min(o_min), .o_busy(o_busy), .o_full(o_full), .o_overflow(o_overflow),
    .o_count(o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  // Reference model state
  logic [7:0] q[$];
  int         edge_n;
  int         next_pop;
  int         pulse_edge;
  logic [4:0] pulse_code;
  bit         m_ovf;

  function automatic logic [4:0] ref_decode(input logic [7:0] b);
    string cmds;
    cmds = "rcmhn";
    for (int i = 0; i < 5; i++) begin
      if (b == cmds[i]) return 5'(1 << i);
`ifdef UART_CMD_UPPER_EN
      if (b == cmds[i] - 8'd32) return 5'(1 << i);
`endif
    end
    return '0;
  endfunction

  task automatic model_reset();
    q.delete();
    edge_n     = 0;
    next_pop   = 0;
    pulse_edge = -1;
    pulse_code = '0;
    m_ovf      = 1'b0;
  endtask

  task automatic model_edge(input logic d, input logic [7:0] b);
    bit         esc, rd;
    logic [7:0] h;
    logic [4:0] code;
    edge_n++;
    esc = d && (b == 8'h1B);
    rd  = !esc && (edge_n >= next_pop) && (q.size() > 0);
    if (esc) begin
      q.delete();
      next_pop   = edge_n + 1;
      pulse_edge = -1;
    end else if (rd) begin
      h    = q.pop_front();
      code = ref_decode(h);
      if (code != '0) begin
        pulse_edge = edge_n + 1;
        pulse_code = code;
        next_pop   = edge_n + 3 + GAPC;
      end else begin
        next_pop = edge_n + 2;
      end
    end
    if (d && !esc) begin
      if (q.size() < DEPTH) q.push_back(b);
      else                  m_ovf = 1'b1;
    end
  endtask

  function automatic logic [4:0] m_pulse();
    return (pulse_edge == edge_n) ? pulse_code : 5'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic check_all();
    logic [4:0] p;
    p = m_pulse();
    chk("run",      32'(o_run),      32'(p[0]));
    chk("clear",    32'(o_clear),    32'(p[1]));
    chk("mode",     32'(o_mode),     32'(p[2]));
    chk("hour",     32'(o_hour),     32'(p[3]));
    chk("min",      32'(o_min),      32'(p[4]));
    chk("busy",     32'(o_busy),     32'((q.size() > 0) || (edge_n < next_pop - 1)));
    chk("full",     32'(o_full),     32'(q.size() == DEPTH));
    chk("overflow", 32'(o_overflow), 32'(m_ovf));
    chk("count",    32'(o_count),    32'(q.size()));
  endtask

  // Called at a negedge; drives inputs, lets one posedge happen, checks at the next negedge.
  task automatic step(input logic d, input logic [7:0] b);
    rx_done = d;
    rx_data = b;
    @(posedge clk);
    model_edge(d, b);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    rx_done = 1'b0;
    rst     = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] tbl [8];
    logic [7:0] burst [6];
    int         waited;
    logic [7:0] b;
    tbl   = '{8'h72, 8'h63, 8'h6D, 8'h68, 8'h6E, 8'h52, 8'h78, 8'h4D};
    burst = '{8'h63, 8'h6D, 8'h68, 8'h6E, 8'h72, 8'h63};
    rst = 1'b0; rx_done = 1'b0; rx_data = '0;
    @(negedge clk);
    do_reset();

    // Single 'r'
    step(1'b1, 8'h72);
    idle(10);

    // Five back-to-back commands
    for (int i = 0; i < 5; i++) step(1'b1, burst[i]);
    idle(32);

    // Ignored byte ahead of a command
    do_reset();
    step(1'b1, 8'h78);
    step(1'b1, 8'h72);
    idle(12);

    // ESC while in GAP with commands still queued
    step(1'b1, 8'h72);
    step(1'b1, 8'h63);
    step(1'b1, 8'h6D);
    idle(3);
    step(1'b1, 8'h1B);
    chk("esc_count", 32'(o_count), 32'd0);
    chk("esc_busy",  32'(o_busy),  32'd0);
    idle(12);

    // Uppercase
    step(1'b1, 8'h52);
    idle(12);

    // Overflowing burst, then reset while o_run is high
    for (int i = 0; i < 6; i++) step(1'b1, burst[i]);
    waited = 0;
    while (!(m_pulse()[0]) && waited < 60) begin
      step(1'b0, 8'h00);
      waited++;
    end
    chk("run_wait_bound", 32'(waited < 60), 32'd1);
    chk("run_before_rst", 32'(o_run), 32'd1);
    do_reset();
    chk("rst_run",      32'(o_run),      32'd0);
    chk("rst_count",    32'(o_count),    32'd0);
    chk("rst_overflow", 32'(o_overflow), 32'd0);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0)      step(1'b1, 8'h1B);
      else if ($urandom_range(0, 2) == 0) begin
        b = tbl[$urandom_range(0, 7)];
        step(1'b1, b);
      end else                             step(1'b0, 8'($urandom));
    end
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
